// File: rtl/soc_system_switch_in_if.sv
// Avalon-MM slave bus bundle for the switch/key input port.
// readdata is registered in the slave and is valid one cycle after address.
interface soc_system_switch_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_switch_in.sv
// Avalon-MM input port: synchronises external switches/keys, latches selected edges
// into a write-1-to-clear capture register and raises a masked level interrupt.
module soc_system_switch_in #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  soc_system_switch_in_if.slave  bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  localparam int unsigned     CNT_W     = 3;
  localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(SYNC_STAGES + 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  mask_q;
  logic [WIDTH-1:0]                  cap_q;
  logic [CNT_W-1:0]                  warm_q;
  logic [31:0]                       readdata_q;
  logic                              irq_q;

  logic [WIDTH-1:0] data_c;
  logic [WIDTH-1:0] edge_raw_c;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] w1c_c;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] cap_d;
  logic [31:0]      rd_mux_c;
  logic             warm_done_c;
  logic             wr_en_c;
  logic             unused_wdata_c;

  assign data_c         = sync_q[SYNC_STAGES-1];
  assign warm_done_c    = (warm_q == WARM_DONE);
  assign unused_wdata_c = ^bus.writedata;

  // Synchroniser chain; the last stage is the architectural DATA register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= data_c;
    end
  end

  // Warm-up counter: holds off capture until the chain and prev hold real samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q <= '0;
    end else if (!warm_done_c) begin
      warm_q <= warm_q + CNT_W'(1);
    end
  end

  // Edge selection
  always_comb begin
    edge_raw_c = '0;
    case (EDGE_TYPE)
      0:       edge_raw_c = data_c & ~prev_q;
      1:       edge_raw_c = ~data_c & prev_q;
      default: edge_raw_c = data_c ^ prev_q;
    endcase
    edge_c = warm_done_c ? edge_raw_c : '0;
  end

  // Register write decode; a fresh edge beats a simultaneous W1C of the same bit
  always_comb begin
    wr_en_c = bus.chipselect && !bus.write_n;
    w1c_c   = '0;
    mask_d  = mask_q;
    if (wr_en_c && (bus.address == ADDR_CAP)) begin
      w1c_c = bus.writedata[WIDTH-1:0];
    end
    if (wr_en_c && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~w1c_c) | edge_c;
  end

  // Read mux over current register contents; reserved address reads zero
  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      ADDR_DATA: rd_mux_c = 32'(data_c);
      ADDR_MASK: rd_mux_c = 32'(mask_q);
      ADDR_CAP:  rd_mux_c = 32'(cap_q);
      default:   rd_mux_c = '0;
    endcase
  end

  // Control/status registers, readback and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= rd_mux_c;
      irq_q      <= |(cap_d & mask_d);
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_switch_in.sv
// Scoreboard bench: three ports (rising/falling/any) share one stimulus stream and are
// compared against a sample-history reference model every clock.
module tb_soc_system_switch_in;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned S     = 2;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic [1:0]       address    = '0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = '0;
  logic [WIDTH-1:0] in_port    = '1;
  logic [2:0]       irq_dut;
  logic [31:0]      rd_dut [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  soc_system_switch_in_if bus0 ();
  soc_system_switch_in_if bus1 ();
  soc_system_switch_in_if bus2 ();

  assign bus0.address = address;  assign bus0.chipselect = chipselect;
  assign bus0.write_n = write_n;  assign bus0.writedata  = writedata;
  assign bus1.address = address;  assign bus1.chipselect = chipselect;
  assign bus1.write_n = write_n;  assign bus1.writedata  = writedata;
  assign bus2.address = address;  assign bus2.chipselect = chipselect;
  assign bus2.write_n = write_n;  assign bus2.writedata  = writedata;
  assign rd_dut[0] = bus0.readdata;
  assign rd_dut[1] = bus1.readdata;
  assign rd_dut[2] = bus2.readdata;

  soc_system_switch_in #(.WIDTH(WIDTH), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq_dut[0]));
  soc_system_switch_in #(.WIDTH(WIDTH), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq_dut[1]));
  soc_system_switch_in #(.WIDTH(WIDTH), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq_dut[2]));

  // ---------------- reference model ----------------
  // s_q[k-1] is the in_port value sampled at the k-th edge after reset release.
  logic [WIDTH-1:0] s_q [$];
  logic [WIDTH-1:0] m_mask [3];
  logic [WIDTH-1:0] m_cap  [3];
  int               n_edge = 0;
  logic [31:0]      exp_rd  [3][$];
  logic             exp_irq [3][$];

  function automatic logic [WIDTH-1:0] samp(input int k);
    if (k < 1 || k > s_q.size()) return '0;
    return s_q[k-1];
  endfunction

  function automatic logic [WIDTH-1:0] edge_of(input int t, input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] old);
    case (t)
      0:       return cur & ~old;
      1:       return ~cur & old;
      default: return cur ^ old;
    endcase
  endfunction

  always @(posedge clk) begin : model_p
    logic [WIDTH-1:0] d_old, p_old, ed, w1c;
    logic [31:0]      rd;
    if (reset) begin
      n_edge = 0;
      s_q.delete();
      for (int t = 0; t < 3; t++) begin
        m_mask[t] = '0;
        m_cap[t]  = '0;
      end
    end else begin
      n_edge++;
      s_q.push_back(in_port);
      // DATA seen before this edge is the sample from S edges earlier; prev one more back
      d_old = samp(n_edge - int'(S));
      p_old = samp(n_edge - int'(S) - 1);
      w1c   = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      for (int t = 0; t < 3; t++) begin
        case (address)
          2'd0:    rd = 32'(d_old);
          2'd2:    rd = 32'(m_mask[t]);
          2'd3:    rd = 32'(m_cap[t]);
          default: rd = '0;
        endcase
        ed = (n_edge >= int'(S) + 2) ? edge_of(t, d_old, p_old) : '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
          if (ed[b])       m_cap[t][b] = 1'b1;
          else if (w1c[b]) m_cap[t][b] = 1'b0;
        end
        if (chipselect && !write_n && address == 2'd2) m_mask[t] = writedata[WIDTH-1:0];
        exp_rd[t].push_back(rd);
        exp_irq[t].push_back(|(m_cap[t] & m_mask[t]));
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at %0t", name, t, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int t = 0; t < 3; t++) begin
      if (exp_rd[t].size() > 0)  check("sb_readdata", t, rd_dut[t], exp_rd[t].pop_front());
      if (exp_irq[t].size() > 0) check("sb_irq", t, 32'(irq_dut[t]), 32'(exp_irq[t].pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    @(negedge clk);
  endtask

  task automatic check_all_rd(input string name, input logic [31:0] exp);
    for (int t = 0; t < 3; t++) check(name, t, rd_dut[t], exp);
  endtask

  task automatic check_all_irq(input string name, input logic exp);
    for (int t = 0; t < 3; t++) check(name, t, 32'(irq_dut[t]), 32'(exp));
  endtask

  initial begin
    // Inputs high across reset release never produce a capture
    in_port = '1;
    tick(3);
    reset = 1'b0;
    tick(10);
    bus_read(2'd0); check_all_rd("rst_hi_data", 32'h0000_00FF);
    bus_read(2'd3); check_all_rd("rst_hi_cap", 32'h0);
    check_all_irq("rst_hi_irq", 1'b0);

    // Rising capture with mask 0x01, then partial and full W1C
    bus_write(2'd2, 32'h01);
    in_port = 8'h00; tick(4);
    bus_write(2'd3, 32'hFF); tick(2);
    in_port = 8'h05; tick(3);
    check("rise_irq", 0, 32'(irq_dut[0]), 32'h1);
    bus_write(2'd3, 32'h04);
    check("w1c_other_irq", 0, 32'(irq_dut[0]), 32'h1);
    bus_read(2'd3);
    check("w1c_other_cap", 0, rd_dut[0], 32'h01);
    bus_write(2'd3, 32'h01);
    check("w1c_irq_clr", 0, 32'(irq_dut[0]), 32'h0);

    // Set wins over a W1C landing on the same edge
    in_port = 8'h0D; tick(3);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h05; tick(4);
    in_port = 8'h0D; tick(2);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3);
    check("set_beats_clr", 0, rd_dut[0], 32'h08);

    // Any-edge capture on both transitions of bit 7
    bus_write(2'd3, 32'hFF);
    in_port = 8'h8D; tick(4);
    bus_read(2'd3);
    check("any_rise", 2, rd_dut[2], 32'h80);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h0D; tick(4);
    bus_read(2'd3);
    check("any_fall", 2, rd_dut[2], 32'h80);
    bus_read(2'd1); check_all_rd("rsvd_read", 32'h0);
    bus_write(2'd0, 32'hAA);
    bus_write(2'd1, 32'h55);
    bus_read(2'd0); check_all_rd("ro_data", 32'(in_port));

    // Randomised traffic with occasional mid-run resets
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12)      in_port = WIDTH'($urandom);
      else if (r < 25) in_port = in_port ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      r = int'($urandom_range(0, 99));
      if (r < 18) begin
        bus_write(2'($urandom_range(0, 3)), $urandom);
      end else if (r < 20) begin
        reset = 1'b1;
        #1;
        check_all_irq("rand_rst_irq", 1'b0);
        check_all_rd("rand_rst_rd", 32'h0);
        tick(1);
        tick(1);
        reset = 1'b0;
      end else begin
        bus_read(2'($urandom_range(0, 3)));
      end
    end

    // Reset while interrupting, then warm-up and first post-warm-up capture
    in_port = '1; tick(6);
    bus_write(2'd2, 32'hFF);
    in_port = 8'h00; tick(4);
    in_port = 8'hFF; tick(4);
    check_all_irq("pre_rst_irq", 1'b1);
    reset = 1'b1;
    #1;
    check_all_irq("async_rst_irq", 1'b0);
    check_all_rd("async_rst_rd", 32'h0);
    tick(2);
    reset = 1'b0;
    tick(8);
    bus_read(2'd3); check_all_rd("warm_cap", 32'h0);
    bus_read(2'd2); check_all_rd("warm_mask", 32'h0);
    in_port = 8'h0F; tick(4);
    bus_read(2'd3);
    check("post_warm_rise", 0, rd_dut[0], 32'h00);
    check("post_warm_fall", 1, rd_dut[1], 32'hF0);
    check("post_warm_any", 2, rd_dut[2], 32'hF0);

    // Changes while still warming up; the scoreboard tracks the outcome
    reset = 1'b1; tick(2);
    reset = 1'b0;
    in_port = 8'h3C; tick(2);
    in_port = 8'hC3; tick(8);
    bus_read(2'd3);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
